// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared states, mode encoding and header sizing for the serial system bus
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA_IN,
        WRITE,
        READ,
        SEND,
        DRAIN
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int hdr_len(input int addr_width, input int len_width);
        return 1 + len_width + addr_width;
    endfunction

endpackage

// File: rtl/serial_slave_mem.sv
// serial_slave_mem: single-port register array, synchronous write, combinational read, no reset
module serial_slave_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [MEM_AW-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Contents persist across reset so the array carries no reset term
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial memory-mapped slave with burst read/write, abort and decode error
module serial_slave_port
    import serial_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 2,
    parameter int                    MEM_DEPTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_wr_bus,
    input  logic i_master_valid,
    input  logic i_master_ready,
    output logic o_rd_bus,
    output logic o_slave_ready,
    output logic o_slave_valid,
    output logic o_wr_done,
    output logic o_dec_err
);

    localparam int H      = hdr_len(ADDR_WIDTH, LEN_WIDTH);
    localparam int HW     = H - 1;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int CW     = $clog2(((H > DATA_WIDTH) ? H : DATA_WIDTH) + 1);
    localparam logic [CW-1:0] HLAST = CW'(H - 1);
    localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [LEN_WIDTH-1:0]  r_words;
    logic                  r_mode;
    logic [HW-2:0]         r_hdr;
    logic [MEM_AW-1:0]     r_idx;
    logic [DATA_WIDTH-1:0] r_sh;
    logic                  r_dec_err;

    logic [HW-1:0]         w_hdr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_hit, w_hdr_last, w_dat_last, w_more, w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    // The final header bit is folded in combinationally so decode happens on its acceptance edge
    assign w_hdr      = {r_hdr, i_wr_bus};
    assign w_addr     = w_hdr[ADDR_WIDTH-1:0];
    assign w_len      = w_hdr[HW-1 -: LEN_WIDTH];
    assign w_hit      = w_addr[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW];
    assign w_hdr_last = r_cnt == HLAST;
    assign w_dat_last = r_cnt == DLAST;
    assign w_more     = r_words != '0;
    assign w_we       = (r_state == WRITE) && rstn;
    assign o_dec_err  = r_dec_err;

    serial_slave_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (r_idx),
        .i_wdata(r_sh),
        .o_rdata(w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and Moore output decode
    always_comb begin
        w_state_nxt   = r_state;
        o_slave_ready = 1'b0;
        o_slave_valid = 1'b0;
        o_wr_done     = 1'b0;
        o_rd_bus      = 1'b0;
        case (r_state)
            IDLE: begin
                o_slave_ready = 1'b1;
                if (i_master_valid) w_state_nxt = HEADER;
            end
            HEADER: begin
                o_slave_ready = 1'b1;
                if (!i_master_valid) w_state_nxt = IDLE;
                else if (w_hdr_last) w_state_nxt = !w_hit ? DRAIN : (r_mode == MODE_WRITE) ? DATA_IN : READ;
            end
            DATA_IN: begin
                o_slave_ready = 1'b1;
                if (!i_master_valid) w_state_nxt = IDLE;
                else if (w_dat_last) w_state_nxt = WRITE;
            end
            WRITE: begin
                o_wr_done   = 1'b1;
                w_state_nxt = w_more ? DATA_IN : IDLE;
            end
            READ: w_state_nxt = SEND;
            SEND: begin
                o_slave_valid = 1'b1;
                o_rd_bus      = r_sh[DATA_WIDTH-1];
                if (!i_master_valid) w_state_nxt = IDLE;
                else if (i_master_ready && w_dat_last) w_state_nxt = w_more ? READ : IDLE;
            end
            DRAIN: if (!i_master_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Header capture, data shifting, bit/word counting and burst address stepping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_words   <= '0;
            r_mode    <= MODE_READ;
            r_hdr     <= '0;
            r_idx     <= '0;
            r_sh      <= '0;
            r_dec_err <= 1'b0;
        end else begin
            r_dec_err <= (r_state == HEADER) && i_master_valid && w_hdr_last && !w_hit;
            case (r_state)
                IDLE: begin
                    if (i_master_valid) begin
                        r_mode <= i_wr_bus;
                        r_cnt  <= CW'(1);
                    end
                end
                HEADER: begin
                    if (!i_master_valid) r_cnt <= '0;
                    else begin
                        r_hdr <= w_hdr[HW-2:0];
                        r_cnt <= w_hdr_last ? '0 : r_cnt + 1'b1;
                        if (w_hdr_last) begin
                            r_idx   <= w_addr[MEM_AW-1:0];
                            r_words <= w_len;
                        end
                    end
                end
                DATA_IN: begin
                    if (!i_master_valid) r_cnt <= '0;
                    else begin
                        r_sh  <= {r_sh[DATA_WIDTH-2:0], i_wr_bus};
                        r_cnt <= w_dat_last ? '0 : r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (w_more) begin
                        r_words <= r_words - 1'b1;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                READ: r_sh <= w_rdata;
                SEND: begin
                    if (!i_master_valid) r_cnt <= '0;
                    else if (i_master_ready) begin
                        r_sh  <= {r_sh[DATA_WIDTH-2:0], 1'b0};
                        r_cnt <= w_dat_last ? '0 : r_cnt + 1'b1;
                        if (w_dat_last && w_more) begin
                            r_words <= r_words - 1'b1;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: randomized self-checking bench against a word-level memory model
module tb_serial_slave_port;

    localparam logic [15:0] BASE = 16'h0000;

    logic clk = 1'b0;
    logic rstn, wr_bus, mv, mr;
    logic rd, sr, sv, wd, de;

    int n_tests = 0;
    int n_fail  = 0;
    int wd_cnt  = 0;
    int de_cnt  = 0;

    logic [7:0]  mem_m [64];
    logic [7:0]  wdat  [4];
    logic [15:0] ra;
    int          rl;
    int          wd0;

    serial_slave_port #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .LEN_WIDTH (2),
        .MEM_DEPTH (64),
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_wr_bus      (wr_bus),
        .i_master_valid(mv),
        .i_master_ready(mr),
        .o_rd_bus      (rd),
        .o_slave_ready (sr),
        .o_slave_valid (sv),
        .o_wr_done     (wd),
        .o_dec_err     (de)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wd) wd_cnt++;
        if (de) de_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input logic [15:0] a);
        return (a / 64) == (BASE / 64);
    endfunction

    task automatic idle();
        @(negedge clk);
        mv = 1'b0;
        mr = 1'b0;
        wr_bus = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int w = 0;
        forever begin
            @(negedge clk);
            mv = 1'b1;
            wr_bus = b;
            if (sr) break;
            w++;
            if (w > 20) begin
                check("ready_timeout", w, 0);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic send_hdr(input logic mode, input int len, input logic [15:0] a);
        send_bit(mode);
        for (int i = 1; i >= 0; i--) send_bit(len[i]);
        for (int i = 15; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic drain_check(input int de0);
        repeat (3) begin
            @(negedge clk);
            mv = 1'b1;
            check("drain_ready", sr, 0);
        end
        idle();
        @(negedge clk);
        check("drain_exit", sr, 1);
        check("dec_err_cnt", de_cnt - de0, 1);
    endtask

    task automatic do_write(input logic [15:0] a, input int len);
        int w0 = wd_cnt;
        int de0 = de_cnt;
        send_hdr(1'b1, len, a);
        if (!hit(a)) begin
            drain_check(de0);
            check("miss_no_wr", wd_cnt - w0, 0);
            return;
        end
        for (int k = 0; k <= len; k++)
            for (int i = 7; i >= 0; i--) send_bit(wdat[k][i]);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("wr_done_cnt", wd_cnt - w0, len + 1);
        check("wr_no_dec_err", de_cnt - de0, 0);
        for (int k = 0; k <= len; k++) mem_m[(int'(a) + k) % 64] = wdat[k];
    endtask

    task automatic do_read(input logic [15:0] a, input int len, input int bp, input int rst_at);
        int de0 = de_cnt;
        int nb = 0;
        int stall = 0;
        int t;
        logic held, pb, first;
        logic [7:0] w;
        send_hdr(1'b0, len, a);
        if (!hit(a)) begin
            drain_check(de0);
            return;
        end
        @(negedge clk);
        mv = 1'b1;
        mr = 1'b0;
        check("read_bubble", sv, 0);
        first = 1'b1;
        held = 1'b0;
        pb = 1'b0;
        for (int k = 0; k <= len; k++) begin
            w = '0;
            for (int i = 0; i < 8; i++) begin
                if (nb == rst_at) begin
                    @(negedge clk);
                    rstn = 1'b0;
                    @(negedge clk);
                    check("rst_sv", sv, 0);
                    check("rst_sr", sr, 1);
                    check("rst_rd", rd, 0);
                    rstn = 1'b1;
                    mv = 1'b0;
                    mr = 1'b0;
                    return;
                end
                t = 0;
                forever begin
                    @(negedge clk);
                    if (first) check("read_lat", sv, 1);
                    first = 1'b0;
                    if (held) begin
                        check("bp_valid", sv, 1);
                        check("bp_data", rd, pb);
                    end
                    mr = (bp == 1) ? ($urandom_range(0, 3) != 0) :
                         (bp == 2 && nb == 3 && stall < 5) ? 1'b0 : 1'b1;
                    if (bp == 2 && !mr) stall++;
                    held = sv && !mr;
                    pb = rd;
                    if (sv && mr) break;
                    t++;
                    if (t > 40) begin
                        check("read_timeout", t, 0);
                        break;
                    end
                end
                w = {w[6:0], rd};
                nb++;
                @(posedge clk);
            end
            check("rd_word", w, mem_m[(int'(a) + k) % 64]);
        end
        if (bp == 2) check("bp_stall_cycles", stall, 5);
        idle();
    endtask

    initial begin
        rstn = 1'b0;
        mv = 1'b0;
        mr = 1'b0;
        wr_bus = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_slave_ready", sr, 1);
        check("rst_slave_valid", sv, 0);
        check("rst_rd_bus", rd, 0);
        check("rst_wr_done", wd, 0);
        check("rst_dec_err", de, 0);
        rstn = 1'b1;

        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
            do_write(16'(j * 4), 3);
        end

        wdat[0] = 8'hA5;
        do_write(16'h0003, 0);
        do_read(16'h0003, 0, 0, -1);

        wdat[0] = 8'h11;
        wdat[1] = 8'h22;
        wdat[2] = 8'h33;
        wdat[3] = 8'h44;
        do_write(16'h003E, 3);
        do_read(16'h003E, 3, 0, -1);

        do_read(16'h0100, 0, 0, -1);

        do_read(16'h0003, 0, 2, -1);

        wd0 = wd_cnt;
        send_hdr(1'b1, 0, 16'h0005);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle();
        @(negedge clk);
        check("abort_idle_sr", sr, 1);
        check("abort_idle_sv", sv, 0);
        @(negedge clk);
        check("abort_no_wr", wd_cnt - wd0, 0);
        do_read(16'h0005, 0, 0, -1);
        wdat[0] = 8'h3C;
        do_write(16'h0005, 0);
        do_read(16'h0005, 0, 0, -1);

        do_read(16'h0003, 0, 0, 3);
        do_read(16'h0003, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? (16'($urandom) | 16'h0040) : 16'($urandom_range(0, 63));
            rl = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
                do_write(ra, rl);
            end else begin
                do_read(ra, rl, 1, -1);
            end
        end

        for (int j = 0; j < 16; j++) do_read(16'(j * 4), 3, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Bit-serial memory-mapped slave for the serial system bus. It is the parametrised successor of the single-word serial slave port. It receives a serial header (mode, burst length, address) and decodes the address against a configurable base window. It then performs single or burst writes and reads on an internal register memory, with read backpressure, abort on master withdrawal, and explicit write-done and decode-error status outputs.

## Interface
- ADDR_WIDTH, 16: bus address width.
- DATA_WIDTH, 8: word width.
- LEN_WIDTH, 2: burst length field width; burst = len+1 words (1..2^LEN_WIDTH).
- MEM_DEPTH, 64: words of internal memory, power of two; MEM_AW = $clog2(MEM_DEPTH).
- BASE_ADDR, 16'h0000: window base; low MEM_AW bits ignored.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- wr_bus  in  1  serial data master→slave.
- master_valid  in  1  master driving a valid bit / transaction active.
- master_ready  in  1  master accepts current rd_bus bit.
- rd_bus  out  1  serial read data slave→master.
- slave_ready  out  1  slave accepts wr_bus bit this cycle.
- slave_valid  out  1  rd_bus bit valid.
- wr_done  out  1  one-cycle pulse per word written to memory.
- dec_err  out  1  one-cycle pulse on address window miss.

## Operation
- Bit transfer master→slave occurs on a clock edge with master_valid && slave_ready. Transfer slave→master occurs with slave_valid && master_ready.
- Header, H = 1+LEN_WIDTH+ADDR_WIDTH bits, sent in this order: mode (1=write, 0=read), len MSB-first, address MSB-first.
- Decode: hit iff addr[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW]. Word index = addr[MEM_AW-1:0].
- Burst address increments by 1 per word and wraps modulo MEM_DEPTH.
- Data is MSB-first in both directions.
- States:
  - IDLE: slave_ready=1. An accepted bit is captured as the mode bit, bit counter=1, go to HEADER.
  - HEADER: slave_ready=1. Shifts in bits. If master_valid=0, abort to IDLE. After bit H is accepted:
    - miss → DRAIN with dec_err pulse;
    - hit and mode=1 → DATA_IN;
    - hit and mode=0 → READ.
  - DATA_IN: slave_ready=1. Shifts DATA_WIDTH bits. If master_valid=0, abort to IDLE; the partial word is discarded. On the last bit → WRITE.
  - WRITE: slave_ready=0, lasts 1 cycle. Writes the word to mem[idx] and pulses wr_done. Then → DATA_IN if words remain, else → IDLE. master_valid is ignored in this state.
  - READ: slave_ready=0, slave_valid=0, lasts 1 cycle. Loads the read shift register from mem[idx], then → SEND.
  - SEND: slave_valid=1, rd_bus = shift register MSB. On master_ready, shift and count. After DATA_WIDTH transfers, → READ if words remain, else → IDLE. If master_valid=0, abort to IDLE.
  - DRAIN: slave_ready=0. Stays until master_valid=0, then → IDLE. This keeps remaining bits from another slave's transaction from being read as a new header.
- Words completed before an abort stay written.
- Memory has no reset; contents persist across transactions and reset.

## Timing
- Reset leaves the block in IDLE: slave_ready=1, slave_valid=0, rd_bus=0, wr_done=0, dec_err=0, counters 0.
- Reset mid-transaction takes effect on the next edge; no write occurs that cycle.
- slave_ready and slave_valid are decoded from the registered state (Moore). rd_bus, wr_done and dec_err are registered or state-decoded with no combinational path from inputs.
- Write latency: wr_done pulses in the cycle after the last data bit of each word is accepted. This adds one ready-low bubble per word.
- Read latency: first slave_valid appears 2 cycles after the last header bit (READ, then SEND). Each subsequent word costs a 1-cycle bubble.
- Backpressure: while master_ready=0 in SEND, rd_bus and slave_valid hold stable.
- Bit counter width: $clog2(max(H, DATA_WIDTH)+1). Word counter width: LEN_WIDTH.

## Structure
- Package serial_bus_pkg holds:
  - the state enum (IDLE, HEADER, DATA_IN, WRITE, READ, SEND, DRAIN);
  - the mode constants (MODE_READ=0, MODE_WRITE=1);
  - a header-length function of ADDR_WIDTH and LEN_WIDTH.
- One sub-module: serial_slave_mem, a single-port DATA_WIDTH×MEM_DEPTH register array with synchronous write and combinational read.

## Test plan
- Default parameters. Write 0xA5 to 0x0003, then read 0x0003 → wr_done pulses once; rd_bus yields 1,0,1,0,0,1,0,1 under slave_valid.
- Burst write len=3 at 0x003E with data 0x11,0x22,0x33,0x44 → 4 wr_done pulses; mem[62]=0x11, mem[63]=0x22, mem[0]=0x33, mem[1]=0x44. Burst read of the same range returns the same sequence.
- Read at 0x0100 (miss) → dec_err pulses once; slave_ready stays 0 until master_valid drops, then returns to 1; memory unchanged.
- Read 0x0003 with master_ready held low for 5 cycles after the 3rd bit → rd_bus holds bit 3 stable; all 8 bits are delivered correctly.
- Write to 0x0005 with master_valid dropped after 3 data bits → back in IDLE, no wr_done, mem[5] unchanged; a following write of 0x3C to 0x0005 succeeds.
- rstn asserted mid-SEND → next cycle slave_valid=0, slave_ready=1; a subsequent read works normally.
